// File: rtl/riscv_rf_wb_arbiter.sv
// Writeback arbiter for the two register-file write ports: the LSU owns port B
// whenever it is valid, and the remaining producers share the leftover slots round-robin.
module riscv_rf_wb_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 1,
  parameter int NUM_REQ    = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             hold_i,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data_i,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]     req_tag_i,
  output logic                             we_a_o,
  output logic [ADDR_WIDTH-1:0]            waddr_a_o,
  output logic [DATA_WIDTH-1:0]            wdata_a_o,
  output logic [TAG_WIDTH-1:0]             wtag_a_o,
  output logic                             we_b_o,
  output logic [ADDR_WIDTH-1:0]            waddr_b_o,
  output logic [DATA_WIDTH-1:0]            wdata_b_o,
  output logic [TAG_WIDTH-1:0]             wtag_b_o
);

  localparam int IW = $clog2(NUM_REQ);

  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [TAG_WIDTH-1:0]  tag_arr  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_arr[g] = req_data_i[g*DATA_WIDTH +: DATA_WIDTH];
    assign tag_arr[g]  = req_tag_i[g*TAG_WIDTH +: TAG_WIDTH];
  end

  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] i);
    return (i == IW'(NUM_REQ-1)) ? IW'(1) : i + IW'(1);
  endfunction

  logic [IW-1:0]      rr_q, rr_d;
  logic [NUM_REQ-1:0] ready_p0;
  logic               gnt_a_p0, gnt_b_p0;
  logic [IW-1:0]      sel_a_p0, sel_b_p0;
  logic [IW-1:0]      idx;
  logic               conflict;

  // Stage p0: grant selection. Port B is claimed by the LSU first so the
  // round-robin scan only ever sees the slots that remain.
  always_comb begin
    ready_p0 = '0;
    gnt_a_p0 = 1'b0;
    gnt_b_p0 = 1'b0;
    sel_a_p0 = '0;
    sel_b_p0 = '0;
    rr_d     = rr_q;
    idx      = rr_q;
    conflict = 1'b0;
    if (!hold_i) begin
      if (req_valid_i[0]) begin
        ready_p0[0] = 1'b1;
        gnt_b_p0    = 1'b1;
      end
      for (int k = 0; k < NUM_REQ-1; k++) begin
        if (req_valid_i[idx] && !(gnt_a_p0 && gnt_b_p0)) begin
          conflict = (gnt_a_p0 && addr_arr[idx] == addr_arr[sel_a_p0]) ||
                     (gnt_b_p0 && addr_arr[idx] == addr_arr[sel_b_p0]);
          if (!conflict) begin
            ready_p0[idx] = 1'b1;
            if (!gnt_a_p0) begin
              gnt_a_p0 = 1'b1;
              sel_a_p0 = idx;
            end else begin
              gnt_b_p0 = 1'b1;
              sel_b_p0 = idx;
            end
            rr_d = rr_next(idx);
          end
        end
        idx = rr_next(idx);
      end
    end
  end

  assign req_ready_o = ready_p0;

  // Stage p1: registered write ports. Writes to x0 consume the slot but never
  // raise we; the payload outputs only move when a real write goes out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q      <= IW'(1);
      we_a_o    <= 1'b0;
      waddr_a_o <= '0;
      wdata_a_o <= '0;
      wtag_a_o  <= '0;
      we_b_o    <= 1'b0;
      waddr_b_o <= '0;
      wdata_b_o <= '0;
      wtag_b_o  <= '0;
    end else begin
      rr_q   <= rr_d;
      we_a_o <= gnt_a_p0 && (addr_arr[sel_a_p0] != '0);
      we_b_o <= gnt_b_p0 && (addr_arr[sel_b_p0] != '0);
      if (gnt_a_p0 && (addr_arr[sel_a_p0] != '0)) begin
        waddr_a_o <= addr_arr[sel_a_p0];
        wdata_a_o <= data_arr[sel_a_p0];
        wtag_a_o  <= tag_arr[sel_a_p0];
      end
      if (gnt_b_p0 && (addr_arr[sel_b_p0] != '0)) begin
        waddr_b_o <= addr_arr[sel_b_p0];
        wdata_b_o <= data_arr[sel_b_p0];
        wtag_b_o  <= tag_arr[sel_b_p0];
      end
    end
  end

endmodule

// File: tb/tb_riscv_rf_wb_arbiter.sv
// Directed bench for riscv_rf_wb_arbiter: priority, round-robin, conflicts,
// x0 writes, hold and reset-during-writeback.
module tb_riscv_rf_wb_arbiter;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int TW = 1;
  localparam int NR = 4;

  logic            clk;
  logic            rst_n;
  logic            hold;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NR*TW-1:0] req_tag;
  logic            we_a_o, we_b_o;
  logic [AW-1:0]   waddr_a_o, waddr_b_o;
  logic [DW-1:0]   wdata_a_o, wdata_b_o;
  logic [TW-1:0]   wtag_a_o, wtag_b_o;

  int n_chk  = 0;
  int n_fail = 0;

  riscv_rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n), .hold_i(hold),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_data_i(req_data), .req_tag_i(req_tag),
    .we_a_o(we_a_o), .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o), .wtag_a_o(wtag_a_o),
    .we_b_o(we_b_o), .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o), .wtag_b_o(wtag_b_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [TW-1:0] t);
    chk("we_a", 64'(we_a_o), 64'(we));
    if (we) begin
      chk("waddr_a", 64'(waddr_a_o), 64'(a));
      chk("wdata_a", 64'(wdata_a_o), 64'(d));
      chk("wtag_a", 64'(wtag_a_o), 64'(t));
    end
  endtask

  task automatic chk_b(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [TW-1:0] t);
    chk("we_b", 64'(we_b_o), 64'(we));
    if (we) begin
      chk("waddr_b", 64'(waddr_b_o), 64'(a));
      chk("wdata_b", 64'(wdata_b_o), 64'(d));
      chk("wtag_b", 64'(wtag_b_o), 64'(t));
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [TW-1:0] t);
    req_valid[i]           = 1'b1;
    req_addr[i*AW +: AW]   = a;
    req_data[i*DW +: DW]   = d;
    req_tag[i*TW +: TW]    = t;
  endtask

  task automatic clr_req(input int i);
    req_valid[i] = 1'b0;
  endtask

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  // Both ports must never write the same register in one cycle.
  always @(negedge clk) begin
    if (rst_n && we_a_o && we_b_o) begin
      n_chk++;
      assert ((waddr_a_o == waddr_b_o) === 1'b0) else begin
        n_fail++;
        $error("FAIL port_addr_clash: waddr_a %0h waddr_b %0h required different", waddr_a_o, waddr_b_o);
      end
    end
  end

  // Requester-side protocol: a valid not yet accepted stays valid with a stable payload.
  logic [NR-1:0]    pend;
  logic [NR*AW-1:0] addr_q;
  logic [NR*DW-1:0] data_q;
  logic [NR*TW-1:0] tag_q;
  initial pend = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (pend[i]) begin
          n_chk++;
          assert ({req_valid[i], req_addr[i*AW +: AW], req_data[i*DW +: DW], req_tag[i*TW +: TW]} ===
                  {1'b1, addr_q[i*AW +: AW], data_q[i*DW +: DW], tag_q[i*TW +: TW]}) else begin
            n_fail++;
            $error("FAIL req_stable[%0d]: valid %0b addr %0h required held", i, req_valid[i], req_addr[i*AW +: AW]);
          end
        end
      end
      pend   = req_valid & ~req_ready;
      addr_q = req_addr;
      data_q = req_data;
      tag_q  = req_tag;
    end
  end

  initial begin
    rst_n     = 1'b0;
    hold      = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    req_tag   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we_a", 64'(we_a_o), 64'(0));
    chk("rst_we_b", 64'(we_b_o), 64'(0));
    chk("rst_waddr_a", 64'(waddr_a_o), 64'(0));
    chk("rst_wdata_b", 64'(wdata_b_o), 64'(0));
    rst_n = 1'b1;
    next_cyc;
    chk("idle_we_a", 64'(we_a_o), 64'(0));
    chk("idle_we_b", 64'(we_b_o), 64'(0));

    // Round-robin: requesters 1..3 valid, LSU idle; rr starts at 1
    for (int i = 1; i < NR; i++) set_req(i, AW'(i), DW'(32'h100 + i), TW'(i & 1));
    #1 chk("rr_c1_ready", 64'(req_ready), 64'(4'b0110));
    next_cyc;
    chk_a(1'b1, 6'd1, 32'h101, 1'b1);
    chk_b(1'b1, 6'd2, 32'h102, 1'b0);
    chk("rr_c2_ready", 64'(req_ready), 64'(4'b1010));
    next_cyc;
    chk_a(1'b1, 6'd3, 32'h103, 1'b1);
    chk_b(1'b1, 6'd1, 32'h101, 1'b1);
    chk("rr_c3_ready", 64'(req_ready), 64'(4'b1100));
    next_cyc;
    chk_a(1'b1, 6'd2, 32'h102, 1'b0);
    chk_b(1'b1, 6'd3, 32'h103, 1'b1);
    clr_req(2); clr_req(3);
    #1 chk("rr_c4_ready", 64'(req_ready), 64'(4'b0010));
    next_cyc;
    chk_a(1'b1, 6'd1, 32'h101, 1'b1);
    chk_b(1'b0, '0, '0, '0);

    // Single request from requester 2
    req_valid = '0;
    set_req(2, 6'd5, 32'hDEADBEEF, 1'b1);
    #1 chk("single_ready", 64'(req_ready), 64'(4'b0100));
    next_cyc;
    chk_a(1'b1, 6'd5, 32'hDEADBEEF, 1'b1);
    chk_b(1'b0, '0, '0, '0);
    req_valid = '0;
    next_cyc;
    chk("idle_after_we_a", 64'(we_a_o), 64'(0));
    chk("idle_hold_waddr_a", 64'(waddr_a_o), 64'(5));

    // Requester 3 alone brings rr back to 1
    set_req(3, 6'd20, 32'h55, 1'b0);
    #1 chk("r3_ready", 64'(req_ready), 64'(4'b1000));
    next_cyc;
    chk_a(1'b1, 6'd20, 32'h55, 1'b0);
    req_valid = '0;

    // LSU priority: one round-robin slot left, req3 waits a cycle
    set_req(0, 6'd7, 32'h11, 1'b0);
    set_req(1, 6'd8, 32'h22, 1'b0);
    set_req(3, 6'd9, 32'h33, 1'b1);
    #1 chk("lsu_ready", 64'(req_ready), 64'(4'b0011));
    next_cyc;
    chk_b(1'b1, 6'd7, 32'h11, 1'b0);
    chk_a(1'b1, 6'd8, 32'h22, 1'b0);
    clr_req(0); clr_req(1);
    #1 chk("lsu_r3_ready", 64'(req_ready), 64'(4'b1000));
    next_cyc;
    chk_a(1'b1, 6'd9, 32'h33, 1'b1);
    chk_b(1'b0, '0, '0, '0);
    req_valid = '0;

    // Address conflict between LSU and requester 2
    set_req(0, 6'd10, 32'hA0, 1'b0);
    set_req(2, 6'd10, 32'hA2, 1'b1);
    #1 chk("conf_ready", 64'(req_ready), 64'(4'b0001));
    next_cyc;
    chk_b(1'b1, 6'd10, 32'hA0, 1'b0);
    chk_a(1'b0, '0, '0, '0);
    clr_req(0);
    #1 chk("conf_r2_ready", 64'(req_ready), 64'(4'b0100));
    next_cyc;
    chk_a(1'b1, 6'd10, 32'hA2, 1'b1);
    chk_b(1'b0, '0, '0, '0);
    req_valid = '0;

    // x0 is accepted but never written; f0 is a normal write
    set_req(1, 6'd0, 32'h77, 1'b1);
    #1 chk("x0_ready", 64'(req_ready), 64'(4'b0010));
    next_cyc;
    chk("x0_we_a", 64'(we_a_o), 64'(0));
    chk("x0_we_b", 64'(we_b_o), 64'(0));
    chk("x0_waddr_a_held", 64'(waddr_a_o), 64'(10));
    set_req(1, 6'd32, 32'h3232, 1'b1);
    #1 chk("f0_ready", 64'(req_ready), 64'(4'b0010));
    next_cyc;
    chk_a(1'b1, 6'd32, 32'h3232, 1'b1);
    req_valid = '0;

    // Hold for 3 cycles with everybody valid; rr stays at 2
    for (int i = 0; i < NR; i++) set_req(i, AW'(11 + i), DW'(32'hB0 + i), 1'b0);
    hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 chk("hold_ready", 64'(req_ready), 64'(0));
      next_cyc;
      chk("hold_we_a", 64'(we_a_o), 64'(0));
      chk("hold_we_b", 64'(we_b_o), 64'(0));
    end
    hold = 1'b0;
    #1 chk("unhold_ready", 64'(req_ready), 64'(4'b0101));
    next_cyc;
    chk_b(1'b1, 6'd11, 32'hB0, 1'b0);
    chk_a(1'b1, 6'd13, 32'hB2, 1'b0);
    clr_req(0); clr_req(2);
    #1 chk("unhold2_ready", 64'(req_ready), 64'(4'b1010));
    next_cyc;
    chk_a(1'b1, 6'd14, 32'hB3, 1'b0);
    chk_b(1'b1, 6'd12, 32'hB1, 1'b0);
    req_valid = '0;

    // Reset pulsed between acceptance and writeback discards the write
    set_req(1, 6'd15, 32'hC1, 1'b1);
    #1 chk("rstp_ready", 64'(req_ready), 64'(4'b0010));
    @(posedge clk);
    #1;
    req_valid = '0;
    rst_n = 1'b0;
    #1 chk("rstp_we_a", 64'(we_a_o), 64'(0));
    chk("rstp_waddr_a", 64'(waddr_a_o), 64'(0));
    #1 rst_n = 1'b1;
    next_cyc;
    chk("rstp_we_a_after", 64'(we_a_o), 64'(0));
    chk("rstp_we_b_after", 64'(we_b_o), 64'(0));

    // Pointer is back at 1 after reset
    for (int i = 1; i < NR; i++) set_req(i, AW'(40 + i), DW'(32'hD0 + i), 1'b0);
    #1 chk("post_rst_ready", 64'(req_ready), 64'(4'b0110));
    next_cyc;
    chk_a(1'b1, 6'd41, 32'hD1, 1'b0);
    chk_b(1'b1, 6'd42, 32'hD2, 1'b0);
    clr_req(1); clr_req(2);
    #1 chk("post_rst_r3_ready", 64'(req_ready), 64'(4'b1000));
    next_cyc;
    chk_a(1'b1, 6'd43, 32'hD3, 1'b0);
    req_valid = '0;
    next_cyc;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
